// File: rtl/srom_loader.sv
// Boot loader: streams WORDS 16-bit words out of an SPI serial ROM into an async SRAM,
// then hands the SRAM to the CPU as instruction memory and raises ready.
module srom_loader #(
    parameter int unsigned WORDS      = 32768,
    parameter logic [23:0] START_BYTE = 24'h000000
) (
    input  logic        clk_srom,
    input  logic        rst,
    input  logic [14:0] address,
    output logic [15:0] data,
    output logic        ready,
    output logic        srom_cs_n,
    output logic        srom_sck,
    output logic        srom_di,
    input  logic        srom_do,
    output logic [14:0] sram_address,
    inout  wire  [15:0] sram_dio,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);
    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_READ, ST_WRITE, ST_DONE} state_t;

    localparam logic [14:0] LAST_IDX = 15'(WORDS - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [14:0] idx_q, idx_d;
    logic [31:0] cmd_q, cmd_d;
    logic [15:0] rx_q, rx_d;
    logic        sck_q, sck_d;
    logic        we_n_q, we_n_d;
    logic        dio_oe;

    always_ff @(posedge clk_srom or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            cmd_q   <= '0;
            rx_q    <= '0;
            sck_q   <= 1'b0;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            rx_q    <= rx_d;
            sck_q   <= sck_d;
            we_n_q  <= we_n_d;
        end
    end

    // cnt_q counts half-bits: even = sck-low cycle, odd = sck-high cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 6'd1;
        idx_d   = idx_q;
        cmd_d   = cmd_q;
        rx_d    = rx_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_CMD;
                cnt_d   = '0;
                cmd_d   = {8'h03, START_BYTE};
            end
            ST_CMD: begin
                if (cnt_q[0]) cmd_d = {cmd_q[30:0], 1'b0};
                if (cnt_q == 6'd63) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                end
            end
            ST_READ: begin
                // sample on the edge that takes sck 0->1
                if (!cnt_q[0]) rx_d = {rx_q[14:0], srom_do};
                if (cnt_q == 6'd31) begin
                    state_d = ST_WRITE;
                    cnt_d   = '0;
                end
            end
            ST_WRITE: begin
                if (cnt_q[0]) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                        idx_d   = idx_q + 15'd1;
                    end
                end
            end
            ST_DONE: cnt_d = '0;
            default: state_d = ST_IDLE;
        endcase
        // sck and we_n come straight from flops so neither can glitch
        sck_d  = (state_d == ST_CMD || state_d == ST_READ) && cnt_d[0];
        we_n_d = !(state_d == ST_WRITE && cnt_d == 6'd0);
    end

    always_comb begin
        srom_cs_n    = 1'b1;
        srom_di      = 1'b0;
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_address = '0;
        data         = '0;
        ready        = 1'b0;
        dio_oe       = 1'b0;
        unique case (state_q)
            ST_CMD: begin
                srom_cs_n = 1'b0;
                srom_di   = cmd_q[31];
            end
            ST_READ: srom_cs_n = 1'b0;
            ST_WRITE: begin
                srom_cs_n    = 1'b0;
                sram_ce_n    = 1'b0;
                sram_address = idx_q;
                dio_oe       = 1'b1;
            end
            ST_DONE: begin
                sram_ce_n    = 1'b0;
                sram_oe_n    = 1'b0;
                sram_address = address;
                data         = sram_dio;
                ready        = 1'b1;
            end
            default: ;
        endcase
    end

    assign srom_sck  = sck_q;
    assign sram_we_n = we_n_q;
    assign sram_dio  = dio_oe ? rx_q : 16'bz;
endmodule

// File: doc/srom_loader.md
SROM_LOADER -- requirements
Module: srom_loader

Interface
REQ-001 SHALL have parameter WORDS, default 32768, meaning the number of 16-bit words copied from serial ROM to SRAM (range 1..32768).
REQ-002 SHALL have parameter START_BYTE, default 24'h000000, meaning the serial ROM byte address of the first word.
REQ-003 SHALL have port clk_srom  in  1  sole clock (25MHz); all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port address  in  15  CPU instruction address (pc), used only in DONE.
REQ-006 SHALL have port data  out  16  instruction word to CPU.
REQ-007 SHALL have port ready  out  1  high once load complete; gates CPU clock upstream.
REQ-008 SHALL have ports srom_cs_n out 1, srom_sck out 1, srom_di out 1 and srom_do in 1, forming an SPI mode-0 master.
REQ-009 SHALL have ports sram_address out 15, sram_dio inout 16, sram_ce_n out 1, sram_oe_n out 1 and sram_we_n out 1, forming an async SRAM port.

Function
REQ-010 SHALL implement states CMD, READ, WRITE and DONE; SHALL enter CMD on the first edge after rst falls.
REQ-011 Each SPI bit SHALL occupy 2 clk_srom cycles: a sck-low cycle, in which srom_di is updated, then a sck-high cycle; srom_sck SHALL be registered and glitch-free.
REQ-012 CMD SHALL drive srom_cs_n=0 and shift 32 bits MSB-first: 8'h03 followed by START_BYTE[23:0]; duration 64 cycles; then go to READ.
REQ-013 READ SHALL shift 16 bits MSB-first (big-endian word) with srom_di=0.
REQ-014 In READ, srom_do SHALL be sampled on the edge at which srom_sck goes 0->1; duration 32 cycles; then go to WRITE.
REQ-015 WRITE SHALL last 2 cycles with srom_sck held 0 and srom_cs_n held 0 (SPI stream paused, not restarted).
REQ-016 WRITE cycle 1 SHALL drive sram_address=word index, sram_dio=assembled word, sram_ce_n=0, sram_we_n=0 and sram_oe_n=1.
REQ-017 WRITE cycle 2 SHALL drive sram_we_n=1, with address and data still driven (hold time).
REQ-018 Word index SHALL be a 15-bit counter starting at 0 and incremented after each WRITE.
REQ-019 After the WRITE for index WORDS-1, the block SHALL go to DONE; otherwise it SHALL return to READ; for WORDS=32768 the last index is 32767 and the counter SHALL NOT wrap before DONE.
REQ-020 DONE SHALL drive srom_cs_n=1, srom_sck=0, sram_ce_n=0, sram_oe_n=0, sram_we_n=1, sram_address=address (combinational pass-through), sram_dio=Z and data=sram_dio.
REQ-021 In DONE, ready SHALL be 1 and the state SHALL be terminal until rst.
REQ-022 Outside DONE, data SHALL be 16'h0000 and ready SHALL be 0.
REQ-023 sram_dio SHALL be driven only in WRITE; Z in every other state.
REQ-024 ready SHALL rise exactly 64 + 34*WORDS cycles after the first post-reset edge; no cycle-early assertion is permitted.

Reset
REQ-025 While rst=1 the block SHALL drive: ready=0, data=0, srom_cs_n=1, srom_sck=0, srom_di=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_address=0, sram_dio=Z; word index, bit counter and shift registers SHALL be 0.
REQ-026 rst asserted mid-load (any state, including WRITE cycle 1) SHALL immediately release srom_cs_n and sram_we_n high; after release the load SHALL restart from CMD and word 0.
REQ-027 rst in DONE SHALL drop ready asynchronously and the block SHALL reload fully.

Verification
REQ-028 WORDS=4, START_BYTE=0, flash model word k = 16'hA5A5^k -> srom_di bits = 0x03000000, SRAM writes 0:A5A5, 1:A5A4, 2:A5A7, 3:A5A6, ready high at cycle 200.
REQ-029 START_BYTE=24'h000100 -> command bits 0x03000100 and the first word is read from byte 0x100.
REQ-030 Pulse rst during the WRITE of word 2 -> we_n=1 and cs_n=1 at once; after release a new 0x03 command is issued and words 0..3 are rewritten; ready at cycle 200 after release.
REQ-031 DONE, address=15'h0003 -> sram_address=3, oe_n=0, ce_n=0, data=16'hA5A6 same cycle; sram_dio never driven by the block.
REQ-032 Whole load -> checker confirms srom_sck period = 2 cycles in CMD/READ, sck=0 throughout WRITE, exactly one we_n low pulse (1 cycle) per word, and cs_n never high before DONE.
